ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/definitions_pkg.sv | 39 +++
 rtl/mul_unit.sv | 76 +++++++
 rtl/ex_stage.sv | 171 +++++++++++++++++
 tb/tb_ex_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/definitions_pkg.sv
// -----------------------------------------------------------------------------
// definitions_pkg
// Shared type definitions for the execute stage and its iterative multiplier.
//   alu_e       : operation select driven by decode (ALU, compare, branch,
//                 multiply, halt)
//   mul_state_e : state encoding of the shift-add multiplier FSM
//   XLEN        : datapath width
// -----------------------------------------------------------------------------
package definitions_pkg;

    localparam int XLEN = 32;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_BEQ,
        ALU_BNE,
        ALU_BLT,
        ALU_BGE,
        ALU_BLTU,
        ALU_BGEU,
        ALU_MUL,
        ALU_HALT
    } alu_e;

    typedef enum logic {
        MUL_IDLE,
        MUL_BUSY
    } mul_state_e;

endpackage

// File: rtl/mul_unit.sv
// -----------------------------------------------------------------------------
// mul_unit
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Returns the low 32 bits of a_i * b_i.
//   clk       in  rising-edge clock
//   rst_n     in  asynchronous active-low reset (aborts any multiply)
//   start_i   in  launch a multiply with a_i/b_i (only honoured when idle)
//   a_i, b_i  in  multiplicand / multiplier
//   busy_o    out FSM is in BUSY (registered state)
//   done_o    out high during the last BUSY cycle; product_o is final then
//   product_o out running/final product
//   state_o   out FSM state, for observation
// Timing: start seen on edge E0 -> BUSY for 32 cycles -> IDLE on edge E32.
// -----------------------------------------------------------------------------
module mul_unit
    import definitions_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] product_o,
    output mul_state_e      state_o
);

    mul_state_e      state_q;
    logic [4:0]      cnt_q;
    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [XLEN-1:0] sum;

    // Partial product for the current multiplier bit; bits shifted past
    // bit 31 of mcand_q fall off, which yields the product modulo 2^32.
    assign sum       = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign busy_o    = (state_q == MUL_BUSY);
    assign done_o    = busy_o && (cnt_q == 5'd31);
    assign product_o = sum;
    assign state_o   = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    if (start_i) begin
                        state_q  <= MUL_BUSY;
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        mcand_q  <= a_i;
                        mplier_q <= b_i;
                    end
                end
                MUL_BUSY: begin
                    acc_q    <= sum;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= MUL_IDLE;
                    end
                end
                default: state_q <= MUL_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage
// Execute stage: single-cycle ALU / compare / branch resolution, sticky halt,
// and (with macro EX_MUL_EN defined) an iterative 32-cycle multiplier.
// Without EX_MUL_EN, ALU_MUL is accepted as a no-op and stall is tied low.
//   clk, rst_n       clock, asynchronous active-low reset
//   valid_in         decode outputs valid this cycle
//   rs1, rs2         source operands
//   imm_data         sign-extended immediate
//   alu_sel          operation select (alu_e)
//   use_imm          operand B = imm_data when 1, else rs2
//   pc               address of the executing instruction
//   wb_data, rf_wen  registered result and 1-cycle write-enable pulse
//   taken, br_addr   registered branch-taken pulse and branch target
//   halting          sticky halt flag, cleared only by reset
//   stall            upstream must hold inputs (multiply in flight)
// Handshake: an instruction is consumed on a rising edge when valid_in=1,
// halting=0 and no multiply is busy; stall=1 tells decode that the current
// instruction (a multiply) occupies the stage and valid_in is not sampled.
// -----------------------------------------------------------------------------
module ex_stage
    import definitions_pkg::*;
#(
    parameter int BR_AW = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [31:0]      rs1,
    input  logic [31:0]      rs2,
    input  logic [31:0]      imm_data,
    input  alu_e             alu_sel,
    input  logic             use_imm,
    input  logic [BR_AW-1:0] pc,
    output logic [31:0]      wb_data,
    output logic             rf_wen,
    output logic             taken,
    output logic [BR_AW-1:0] br_addr,
    output logic             halting,
    output logic             stall
);

    logic [31:0]      wb_data_q, wb_data_d;
    logic             rf_wen_q, rf_wen_d;
    logic             taken_q, taken_d;
    logic [BR_AW-1:0] br_addr_q, br_addr_d;
    logic             halting_q, halting_d;

    logic [31:0]      op_b;
    logic [4:0]       shamt;
    logic [BR_AW-1:0] br_target;
    logic             accept;
    logic             mul_busy;

    logic [31:0]      alu_res;
    logic             alu_wen;
    logic             is_br;
    logic             br_cond;
    logic             halt_op;

    assign op_b      = use_imm ? imm_data : rs2;
    assign shamt     = op_b[4:0];
    // Truncating add: wrap-around of the branch target is intentional.
    assign br_target = pc + imm_data[BR_AW-1:0];
    assign accept    = valid_in && !halting_q && !mul_busy;

`ifdef EX_MUL_EN
    logic        mul_start;
    logic        mul_done;
    logic [31:0] mul_product;
    mul_state_e  mul_state;

    assign mul_start = accept && (alu_sel == ALU_MUL);
    // High from the acceptance cycle through the last BUSY cycle.
    assign stall     = mul_busy || mul_start;

    mul_unit u_mul_unit (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (rs1),
        .b_i       (op_b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product),
        .state_o   (mul_state)
    );
`else
    assign mul_busy = 1'b0;
    assign stall    = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        alu_wen = 1'b0;
        is_br   = 1'b0;
        br_cond = 1'b0;
        halt_op = 1'b0;
        case (alu_sel)
            ALU_ADD:  begin alu_res = rs1 + op_b; alu_wen = 1'b1; end
            ALU_SUB:  begin alu_res = rs1 - op_b; alu_wen = 1'b1; end
            ALU_AND:  begin alu_res = rs1 & op_b; alu_wen = 1'b1; end
            ALU_OR:   begin alu_res = rs1 | op_b; alu_wen = 1'b1; end
            ALU_XOR:  begin alu_res = rs1 ^ op_b; alu_wen = 1'b1; end
            ALU_SLL:  begin alu_res = rs1 << shamt; alu_wen = 1'b1; end
            ALU_SRL:  begin alu_res = rs1 >> shamt; alu_wen = 1'b1; end
            ALU_SRA:  begin alu_res = $unsigned($signed(rs1) >>> shamt); alu_wen = 1'b1; end
            ALU_SLT:  begin alu_res = {31'd0, $signed(rs1) < $signed(op_b)}; alu_wen = 1'b1; end
            ALU_SLTU: begin alu_res = {31'd0, rs1 < op_b}; alu_wen = 1'b1; end
            ALU_BEQ:  begin is_br = 1'b1; br_cond = (rs1 == rs2); end
            ALU_BNE:  begin is_br = 1'b1; br_cond = (rs1 != rs2); end
            ALU_BLT:  begin is_br = 1'b1; br_cond = ($signed(rs1) <  $signed(rs2)); end
            ALU_BGE:  begin is_br = 1'b1; br_cond = ($signed(rs1) >= $signed(rs2)); end
            ALU_BLTU: begin is_br = 1'b1; br_cond = (rs1 <  rs2); end
            ALU_BGEU: begin is_br = 1'b1; br_cond = (rs1 >= rs2); end
            ALU_HALT: halt_op = 1'b1;
            default:  ; // ALU_MUL is handled by the multiplier path
        endcase
    end

    always_comb begin
        wb_data_d = wb_data_q;
        rf_wen_d  = 1'b0;
        taken_d   = 1'b0;
        br_addr_d = br_addr_q;
        halting_d = halting_q;
        if (accept) begin
            if (alu_wen) begin
                wb_data_d = alu_res;
                rf_wen_d  = 1'b1;
            end
            if (is_br) begin
                taken_d   = br_cond;
                br_addr_d = br_target;
            end
            if (halt_op) begin
                halting_d = 1'b1;
            end
        end
`ifdef EX_MUL_EN
        // Never coincides with accept: the multiplier is busy until done.
        if (mul_done) begin
            wb_data_d = mul_product;
            rf_wen_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data_q <= '0;
            rf_wen_q  <= 1'b0;
            taken_q   <= 1'b0;
            br_addr_q <= '0;
            halting_q <= 1'b0;
        end else begin
            wb_data_q <= wb_data_d;
            rf_wen_q  <= rf_wen_d;
            taken_q   <= taken_d;
            br_addr_q <= br_addr_d;
            halting_q <= halting_d;
        end
    end

    assign wb_data = wb_data_q;
    assign rf_wen  = rf_wen_q;
    assign taken   = taken_q;
    assign br_addr = br_addr_q;
    assign halting = halting_q;

endmodule

// File: tb/tb_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_stage
// Directed bench for ex_stage. Each issued instruction pushes its expected
// {rf_wen, wb_data, taken, br_addr} onto exp_q; the sample after the
// following rising edge pops and compares. Multiplier sections follow the
// EX_MUL_EN build option.
// -----------------------------------------------------------------------------
module tb_ex_stage;
    import definitions_pkg::*;

    localparam int BR_AW = 10;
    localparam int EW    = 1 + 32 + 1 + BR_AW;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid_in;
    logic [31:0]      rs1, rs2, imm_data;
    alu_e             alu_sel;
    logic             use_imm;
    logic [BR_AW-1:0] pc;
    logic [31:0]      wb_data;
    logic             rf_wen, taken, halting, stall;
    logic [BR_AW-1:0] br_addr;

    always #5 clk = ~clk;

    ex_stage #(.BR_AW(BR_AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .rs1      (rs1),
        .rs2      (rs2),
        .imm_data (imm_data),
        .alu_sel  (alu_sel),
        .use_imm  (use_imm),
        .pc       (pc),
        .wb_data  (wb_data),
        .rf_wen   (rf_wen),
        .taken    (taken),
        .br_addr  (br_addr),
        .halting  (halting),
        .stall    (stall)
    );

    // ---------------- scoreboard state ----------------
    int               checks = 0;
    int               errors = 0;
    logic [EW-1:0]    exp_q[$];
    logic [31:0]      m_wb;
    logic [BR_AW-1:0] m_br;
    string            cur_tag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input alu_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic ui, input logic [BR_AW-1:0] p);
        @(negedge clk);
        cur_tag  = op.name();
        alu_sel  = op;
        rs1      = a;
        rs2      = b;
        imm_data = im;
        use_imm  = ui;
        pc       = p;
        valid_in = 1'b1;
    endtask

    task automatic compare_head();
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            chk({cur_tag, ".queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({cur_tag, ".rf_wen"},  {31'd0, rf_wen}, {31'd0, e[EW-1]});
            chk({cur_tag, ".wb_data"}, wb_data, e[EW-2 -: 32]);
            chk({cur_tag, ".taken"},   {31'd0, taken}, {31'd0, e[BR_AW]});
            chk({cur_tag, ".br_addr"}, {22'd0, br_addr}, {22'd0, e[BR_AW-1:0]});
        end
    endtask

    task automatic collect();
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        compare_head();
    endtask

    task automatic alu_op(input alu_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic ui, input logic [31:0] expv);
        drive(op, a, b, im, ui, '0);
        exp_q.push_back({1'b1, expv, 1'b0, m_br});
        m_wb = expv;
        collect();
    endtask

    task automatic br_op(input alu_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [BR_AW-1:0] p, input logic [31:0] im, input logic exp_taken);
        logic [BR_AW-1:0] im_lo;
        im_lo = im[BR_AW-1:0];
        m_br  = p + im_lo;
        drive(op, a, b, im, 1'b0, p);
        exp_q.push_back({1'b0, m_wb, exp_taken, m_br});
        collect();
    endtask

    // Instruction that must leave every output at its held value.
    task automatic ignored_op(input alu_e op, input logic [31:0] a, input logic [31:0] b,
                              input logic [BR_AW-1:0] p, input logic [31:0] im);
        drive(op, a, b, im, 1'b0, p);
        exp_q.push_back({1'b0, m_wb, 1'b0, m_br});
        collect();
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        cur_tag  = "IDLE";
        valid_in = 1'b0;
        exp_q.push_back({1'b0, m_wb, 1'b0, m_br});
        collect();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] a, b, im;
        logic        ui;
        int          n;
        int          wen_seen;

        rst_n    = 1'b0;
        valid_in = 1'b0;
        rs1      = '0;
        rs2      = '0;
        imm_data = '0;
        alu_sel  = ALU_ADD;
        use_imm  = 1'b0;
        pc       = '0;
        m_wb     = '0;
        m_br     = '0;

        // Reset state
        #12;
        chk("reset.wb_data", wb_data, 32'd0);
        chk("reset.rf_wen",  {31'd0, rf_wen}, 32'd0);
        chk("reset.taken",   {31'd0, taken}, 32'd0);
        chk("reset.br_addr", {22'd0, br_addr}, 32'd0);
        chk("reset.halting", {31'd0, halting}, 32'd0);
        chk("reset.stall",   {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Arithmetic / logic, wrap-around add
        alu_op(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'h0000_0000);
        idle_cycle();
        alu_op(ALU_ADD, 32'd100, 32'd7, 32'hFFFF_FFFF, 1'b1, 32'd99);
        alu_op(ALU_SUB, 32'd3, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFE);
        alu_op(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 1'b0, 32'h00F0_1200);
        alu_op(ALU_OR,  32'h1200_0000, 32'h0000_0034, 32'd0, 1'b0, 32'h1200_0034);
        alu_op(ALU_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0, 1'b0, 32'hF0F0_0F0F);
        // Shifts use only operand B[4:0]
        alu_op(ALU_SLL, 32'd1, 32'd35, 32'd0, 1'b0, 32'd8);
        alu_op(ALU_SRL, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 32'h0800_0000);
        alu_op(ALU_SRA, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 32'hF800_0000);
        alu_op(ALU_SRA, 32'h4000_0000, 32'd1, 32'd0, 1'b0, 32'h2000_0000);
        // Set-less-than
        alu_op(ALU_SLT,  32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 32'd1);
        alu_op(ALU_SLTU, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 32'd0);
        alu_op(ALU_SLT,  32'd5, 32'd5, 32'd0, 1'b0, 32'd0);
        alu_op(ALU_SLTU, 32'd0, 32'd1, 32'd0, 1'b0, 32'd1);

        // Branches: never write, target wraps silently
        br_op(ALU_BLT,  32'hFFFF_FFFF, 32'd0, 10'h3F0, 32'h20, 1'b1);
        br_op(ALU_BEQ,  32'd5, 32'd6, 10'h100, 32'd4, 1'b0);
        br_op(ALU_BNE,  32'd5, 32'd6, 10'h000, 32'd8, 1'b1);
        br_op(ALU_BGE,  32'hFFFF_FFFF, 32'd0, 10'h010, 32'hFFFF_FFF0, 1'b0);
        br_op(ALU_BLTU, 32'hFFFF_FFFF, 32'd0, 10'h020, 32'd2, 1'b0);
        br_op(ALU_BGEU, 32'hFFFF_FFFF, 32'd0, 10'h030, 32'd3, 1'b1);
        br_op(ALU_BEQ,  32'd7, 32'd7, 10'h3FF, 32'd1, 1'b1);
        idle_cycle();

        // Random adds
        for (int i = 0; i < 8; i++) begin
            a  = $urandom;
            b  = $urandom;
            im = $urandom;
            ui = 1'($urandom_range(0, 1));
            alu_op(ALU_ADD, a, b, im, ui, a + (ui ? im : b));
        end

`ifdef EX_MUL_EN
        // Multiply 7*6: stall for 33 cycles, then one write pulse
        drive(ALU_MUL, 32'd7, 32'd6, 32'd0, 1'b0, '0);
        #1;
        chk("MUL.stall_at_accept", {31'd0, stall}, 32'd1);
        n = stall ? 1 : 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            if (!stall) break;
            n++;
        end
        chk("MUL.stall_cycles", n, 32'd33);
        exp_q.push_back({1'b1, 32'd42, 1'b0, m_br});
        m_wb = 32'd42;
        compare_head();
        idle_cycle();

        // Reset in the middle of a multiply aborts it
        drive(ALU_MUL, 32'd7, 32'd6, 32'd0, 1'b0, '0);
        repeat (10) @(posedge clk);
        valid_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("MUL_abort.stall", {31'd0, stall}, 32'd0);
        chk("MUL_abort.wb_data", wb_data, 32'd0);
        m_wb = '0;
        m_br = '0;
        @(negedge clk);
        rst_n = 1'b1;
        wen_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (rf_wen) wen_seen++;
            if (stall) wen_seen++;
        end
        chk("MUL_abort.no_write", wen_seen, 32'd0);
        chk("MUL_abort.wb_hold", wb_data, 32'd0);
`else
        // Multiply compiled out: no-op, never stalls
        drive(ALU_MUL, 32'd7, 32'd6, 32'd0, 1'b0, '0);
        #1;
        chk("MUL.stall_at_accept", {31'd0, stall}, 32'd0);
        exp_q.push_back({1'b0, m_wb, 1'b0, m_br});
        collect();
        chk("MUL.stall_after", {31'd0, stall}, 32'd0);
        idle_cycle();
`endif

        // Halt is sticky and blocks further instructions
        ignored_op(ALU_HALT, 32'd0, 32'd0, '0, 32'd0);
        chk("HALT.halting", {31'd0, halting}, 32'd1);
        ignored_op(ALU_ADD, 32'd1, 32'd2, '0, 32'd0);
        chk("HALT.after_add", {31'd0, halting}, 32'd1);
        ignored_op(ALU_BLT, 32'hFFFF_FFFF, 32'd0, 10'h3F0, 32'h20);
        idle_cycle();
        chk("HALT.still", {31'd0, halting}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("HALT.reset_clears", {31'd0, halting}, 32'd0);
        m_wb = '0;
        m_br = '0;
        @(negedge clk);
        rst_n = 1'b1;
        alu_op(ALU_ADD, 32'd2, 32'd3, 32'd0, 1'b0, 32'd5);

        // Final report
        chk("scoreboard.drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
